banked_memory: RTL and testbench

- Successor of the byte-array data/instruction memory: parametrised depth, four byte-lane banks with synchronous (registered) reads, and req/ready handshakes on both ports.
- Supports the MIPS load/store modes byte, half, word, lwl/lwr and swl/swr.
- After reset, a clear state machine initialises every word before either port accepts traffic.
- Sits between the CPU datapath (data port) and the fetch stage (instruction port).

---
 rtl/MemoryModes.sv | 129 ++++++++++++
 rtl/memory_byte_lane.sv | 33 +++
 rtl/banked_memory.sv | 174 +++++++++++++++++
 tb/tb_banked_memory.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/MemoryModes.sv
// Shared load/store mode encoding, clear-sequencer states and byte-lane helpers
// used by banked_memory and its four byte-lane RAMs.
package MemoryModes;

  localparam int LANES = 4;

  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BYTE      = 3'd1,
    HALFWORD  = 3'd2,
    WORD      = 3'd3,
    WORDLEFT  = 3'd4,
    WORDRIGHT = 3'd5
  } readWriteModes;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } memState;

  typedef struct packed {
    logic [LANES-1:0] we;
    logic [31:0]      data;
  } lane_write_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [LANES-1:0] mask;
  } load_result_t;

  // Per-lane write enables and byte placement for a store within one aligned word.
  function automatic lane_write_t store_plan(readWriteModes mode, logic [1:0] k,
                                             logic [31:0] wdata);
    lane_write_t p;
    int ki;
    p.we   = 4'b0000;
    p.data = 32'h0000_0000;
    ki     = int'(k);
    for (int i = 0; i < LANES; i++) begin
      case (mode)
        BYTE: begin
          if (i == ki) begin
            p.we[i] = 1'b1;
            p.data[8*i +: 8] = wdata[7:0];
          end
        end
        HALFWORD: begin
          if ((i / 2) == int'(k[1])) begin
            p.we[i] = 1'b1;
            p.data[8*i +: 8] = wdata[8*(i%2) +: 8];
          end
        end
        WORD: begin
          p.we[i] = 1'b1;
          p.data[8*i +: 8] = wdata[8*i +: 8];
        end
        WORDLEFT: begin
          if (i <= ki) begin
            p.we[i] = 1'b1;
            p.data[8*i +: 8] = wdata[8*(i+3-ki) +: 8];
          end
        end
        WORDRIGHT: begin
          if (i >= ki) begin
            p.we[i] = 1'b1;
            p.data[8*i +: 8] = wdata[8*(i-ki) +: 8];
          end
        end
        default: p.we[i] = 1'b0;
      endcase
    end
    return p;
  endfunction

  // Lane selection, extension and merge mask for a load from one aligned word.
  function automatic load_result_t load_format(readWriteModes mode, logic [1:0] k,
                                               logic uns, logic [31:0] word);
    load_result_t r;
    logic [7:0]  b;
    logic [15:0] h;
    int ki;
    r.data = 32'h0000_0000;
    r.mask = 4'b0000;
    ki     = int'(k);
    b      = word[8*ki +: 8];
    h      = word[16*int'(k[1]) +: 16];
    case (mode)
      BYTE: begin
        r.data = {{24{b[7] & ~uns}}, b};
        r.mask = 4'b1111;
      end
      HALFWORD: begin
        r.data = {{16{h[15] & ~uns}}, h};
        r.mask = 4'b1111;
      end
      WORD: begin
        r.data = word;
        r.mask = 4'b1111;
      end
      WORDLEFT: begin
        for (int j = 0; j < LANES; j++) begin
          if (j >= 3 - ki) begin
            r.data[8*j +: 8] = word[8*(j-3+ki) +: 8];
            r.mask[j] = 1'b1;
          end
        end
      end
      WORDRIGHT: begin
        for (int j = 0; j < LANES; j++) begin
          if (j + ki <= 3) begin
            r.data[8*j +: 8] = word[8*(j+ki) +: 8];
            r.mask[j] = 1'b1;
          end
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic align_fault(readWriteModes mode, logic [1:0] k);
    case (mode)
      HALFWORD: return k[0];
      WORD:     return (k != 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_byte_lane.sv
// One byte lane of banked_memory: 2^IDX_W x 8 RAM, one write port and two
// registered read ports (read-first against a same-cycle write).
module memory_byte_lane #(
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_a_i,
  output logic [7:0]       rdata_a_o,
  input  logic [IDX_W-1:0] raddr_b_i,
  output logic [7:0]       rdata_b_o
);

  localparam int DEPTH = 1 << IDX_W;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_a_q;
  logic [7:0] rdata_b_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_a_q <= mem_q[raddr_a_i];
    rdata_b_q <= mem_q[raddr_b_i];
  end

  assign rdata_a_o = rdata_a_q;
  assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/banked_memory.sv
// Four-bank byte-lane memory with a data port (MIPS load/store modes) and a fetch port.
// Optional alignment fault reporting is enabled by defining MEMORY_ALIGN_CHECK_EN.
module banked_memory
  import MemoryModes::*;
#(
  parameter int          ADDR_WIDTH  = 16,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_mode,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_byte_mask,
  output logic        rsp_fault,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  memState          state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;

  logic             run_s;
  readWriteModes    mode_s;
  logic [1:0]       k_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [IDX_W-1:0] if_idx_s;
  logic             req_acc_s;
  logic             if_acc_s;
  logic             fault_s;
  logic             store_s;
  lane_write_t      plan_s;
  logic [LANES-1:0] lane_we_s;
  logic [IDX_W-1:0] lane_widx_s;
  logic [31:0]      lane_wdata_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      if_word_s;
  load_result_t     load_s;
  logic             unused_s;

  logic             rsp_valid_q;
  logic             rsp_fault_q;
  logic             if_rsp_valid_q;
  readWriteModes    ld_mode_q;
  logic [1:0]       ld_k_q;
  logic             ld_uns_q;

  assign run_s     = (state_q == RUN);
  assign req_ready = run_s;
  assign if_ready  = run_s;
  assign req_acc_s = req_valid && run_s;
  assign if_acc_s  = if_valid && run_s;

  assign mode_s    = readWriteModes'(req_mode);
  assign k_s       = req_addr[1:0];
  assign req_idx_s = req_addr[ADDR_WIDTH-1:2];
  assign if_idx_s  = if_addr[ADDR_WIDTH-1:2];
  assign unused_s  = ^{req_addr[31:ADDR_WIDTH], if_addr[31:ADDR_WIDTH], if_addr[1:0]};

`ifdef MEMORY_ALIGN_CHECK_EN
  assign fault_s = align_fault(mode_s, k_s);
`else
  assign fault_s = 1'b0;
`endif

  assign store_s = req_acc_s && req_write && !fault_s;
  assign plan_s  = store_plan(mode_s, k_s, req_wdata);

  // Clear sequencer: one word per cycle from index 0 to the last, then RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == {IDX_W{1'b1}}) begin
          state_d = RUN;
        end else begin
          state_d = CLEAR;
        end
      end
      RUN: begin
        state_d   = RUN;
        clr_cnt_d = '0;
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The single RAM write port belongs to the clear sequencer until RUN.
  always_comb begin
    lane_we_s    = 4'b0000;
    lane_widx_s  = req_idx_s;
    lane_wdata_s = plan_s.data;
    if (!run_s) begin
      lane_we_s    = 4'b1111;
      lane_widx_s  = clr_cnt_q;
      lane_wdata_s = CLEAR_VALUE;
    end else if (store_s) begin
      lane_we_s    = plan_s.we;
    end else begin
      lane_we_s    = 4'b0000;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    memory_byte_lane #(
      .IDX_W(IDX_W)
    ) u_lane (
      .clk      (clk),
      .we_i     (lane_we_s[g]),
      .waddr_i  (lane_widx_s),
      .wdata_i  (lane_wdata_s[8*g +: 8]),
      .raddr_a_i(req_idx_s),
      .rdata_a_o(rd_word_s[8*g +: 8]),
      .raddr_b_i(if_idx_s),
      .rdata_b_o(if_word_s[8*g +: 8])
    );
  end

  // Response bookkeeping travels alongside the registered RAM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q    <= 1'b0;
      rsp_fault_q    <= 1'b0;
      if_rsp_valid_q <= 1'b0;
      ld_mode_q      <= NONE;
      ld_k_q         <= 2'b00;
      ld_uns_q       <= 1'b0;
    end else begin
      rsp_valid_q    <= req_acc_s && (!req_write || fault_s);
      rsp_fault_q    <= req_acc_s && fault_s;
      if_rsp_valid_q <= if_acc_s;
      if (req_acc_s) begin
        ld_mode_q <= mode_s;
        ld_k_q    <= k_s;
        ld_uns_q  <= req_unsigned;
      end
    end
  end

  assign load_s        = load_format(ld_mode_q, ld_k_q, ld_uns_q, rd_word_s);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_fault     = rsp_fault_q;
  assign rsp_data      = (rsp_valid_q && !rsp_fault_q) ? load_s.data : 32'h0000_0000;
  assign rsp_byte_mask = (rsp_valid_q && !rsp_fault_q) ? load_s.mask : 4'b0000;
  assign if_rsp_valid  = if_rsp_valid_q;
  assign if_rsp_data   = if_rsp_valid_q ? if_word_s : 32'h0000_0000;

endmodule

// File: tb/tb_banked_memory.sv
// Self-checking bench for banked_memory: directed vector table, hand sequences
// for clear/reset/fetch corner cases, and random traffic against a byte-array model.
module tb_banked_memory;
  import MemoryModes::*;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << (AW - 2);
  localparam int          BYTES = 1 << AW;
  localparam logic [31:0] CV    = 32'hA5C3_0F69;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_write, req_unsigned;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata, rsp_data, if_addr, if_rsp_data;
  logic        rsp_valid, rsp_fault, if_valid, if_ready, if_rsp_valid;
  logic [3:0]  rsp_byte_mask;

  int errors = 0;
  int checks = 0;
  logic [7:0] m [BYTES];

  always #5 clk = ~clk;

  banked_memory #(.ADDR_WIDTH(AW), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_mode(req_mode), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_byte_mask(rsp_byte_mask), .rsp_fault(rsp_fault),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; if_valid = 1'b0;
  endtask

  task automatic model_clear();
    logic [31:0] cvv;
    cvv = CV;
    for (int i = 0; i < BYTES; i++) m[i] = cvv[8*(i%4) +: 8];
  endtask

  function automatic logic [31:0] mword(int unsigned a);
    return {m[a+3], m[a+2], m[a+1], m[a]};
  endfunction

  function automatic logic model_fault(readWriteModes md, int unsigned k);
`ifdef MEMORY_ALIGN_CHECK_EN
    return (md == HALFWORD && (k % 2) == 1) || (md == WORD && k != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Drive one cycle on both ports, predict from the byte array, then compare.
  task automatic xfer(input logic v, input logic w, input readWriteModes md, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic fv, input logic [31:0] faddr);
    int unsigned a, wa, k, ha, fa;
    logic ev, ef, flt;
    logic [31:0] ed, efd, t;
    logic [15:0] h;
    logic [3:0] em;
    a = addr % BYTES; wa = a - (a % 4); k = a % 4; ha = a - (a % 2);
    fa = faddr % BYTES; fa = fa - (fa % 4);
    efd = mword(fa);
    ev = 1'b0; ef = 1'b0; ed = 32'h0; em = 4'h0;
    if (v) begin
      flt = model_fault(md, k);
      if (flt) begin
        ev = 1'b1; ef = 1'b1;
      end else if (!w) begin
        ev = 1'b1;
        case (md)
          BYTE:      begin ed = uns ? {24'h0, m[a]} : {{24{m[a][7]}}, m[a]}; em = 4'hF; end
          HALFWORD:  begin h = {m[ha+1], m[ha]}; ed = uns ? {16'h0, h} : {{16{h[15]}}, h}; em = 4'hF; end
          WORD:      begin ed = mword(wa); em = 4'hF; end
          WORDLEFT:  begin ed = mword(wa) << (8*(3-k)); em = 4'hF << (3-k); end
          WORDRIGHT: begin ed = mword(wa) >> (8*k); em = 4'hF >> k; end
          default:   begin ed = 32'h0; em = 4'h0; end
        endcase
      end else begin
        case (md)
          BYTE:      m[a] = wd[7:0];
          HALFWORD:  begin m[ha] = wd[7:0]; m[ha+1] = wd[15:8]; end
          WORD:      for (int i = 0; i < 4; i++) m[wa+i] = wd[8*i +: 8];
          WORDLEFT:  begin t = wd >> (8*(3-k)); for (int i = 0; i <= int'(k); i++) m[wa+i] = t[8*i +: 8]; end
          WORDRIGHT: begin t = wd << (8*k); for (int i = int'(k); i < 4; i++) m[wa+i] = t[8*i +: 8]; end
          default:   t = 32'h0;
        endcase
      end
    end
    req_valid = v; req_write = w; req_mode = md; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; if_valid = fv; if_addr = faddr;
    step();
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_fault", rsp_fault, ef);
    if (ev) begin
      chk("rsp_data", rsp_data, ed);
      chk("rsp_byte_mask", rsp_byte_mask, em);
    end
    chk("if_rsp_valid", if_rsp_valid, fv);
    if (fv) chk("if_rsp_data", if_rsp_data, efd);
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < DEPTH + 8) begin
      step();
      n++;
    end
    chk(nm, n, DEPTH);
    chk("if_ready after clear", if_ready, 1'b1);
    model_clear();
  endtask

  typedef struct {
    logic w; readWriteModes md; logic uns; logic [31:0] addr; logic [31:0] wd;
    logic ev; logic [31:0] ed; logic [3:0] em;
  } vec_t;
  vec_t tbl [19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, fa2;
    tbl[0]  = '{1'b0, WORD,      1'b0, 32'h00, 32'h0,          1'b1, CV,           4'hF};
    tbl[1]  = '{1'b1, WORD,      1'b0, 32'h10, 32'h1122_3344,  1'b0, 32'h0,        4'h0};
    tbl[2]  = '{1'b0, BYTE,      1'b0, 32'h13, 32'h0,          1'b1, 32'h0000_0011, 4'hF};
    tbl[3]  = '{1'b0, BYTE,      1'b0, 32'h10, 32'h0,          1'b1, 32'h0000_0044, 4'hF};
    tbl[4]  = '{1'b0, HALFWORD,  1'b0, 32'h12, 32'h0,          1'b1, 32'h0000_1122, 4'hF};
    tbl[5]  = '{1'b1, BYTE,      1'b0, 32'h20, 32'h0000_00F0,  1'b0, 32'h0,        4'h0};
    tbl[6]  = '{1'b0, BYTE,      1'b0, 32'h20, 32'h0,          1'b1, 32'hFFFF_FFF0, 4'hF};
    tbl[7]  = '{1'b0, BYTE,      1'b1, 32'h20, 32'h0,          1'b1, 32'h0000_00F0, 4'hF};
    tbl[8]  = '{1'b1, WORD,      1'b0, 32'h30, 32'h1122_3344,  1'b0, 32'h0,        4'h0};
    tbl[9]  = '{1'b0, WORDLEFT,  1'b0, 32'h31, 32'h0,          1'b1, 32'h3344_0000, 4'hC};
    tbl[10] = '{1'b0, WORDRIGHT, 1'b0, 32'h31, 32'h0,          1'b1, 32'h0011_2233, 4'h7};
    tbl[11] = '{1'b1, WORD,      1'b0, 32'h40, 32'h0,          1'b0, 32'h0,        4'h0};
    tbl[12] = '{1'b1, WORDRIGHT, 1'b0, 32'h42, 32'hAABB_CCDD,  1'b0, 32'h0,        4'h0};
    tbl[13] = '{1'b0, WORD,      1'b0, 32'h40, 32'h0,          1'b1, 32'hCCDD_0000, 4'hF};
    tbl[14] = '{1'b1, WORDLEFT,  1'b0, 32'h40, 32'hAABB_CCDD,  1'b0, 32'h0,        4'h0};
    tbl[15] = '{1'b0, WORD,      1'b0, 32'h40, 32'h0,          1'b1, 32'hCCDD_00AA, 4'hF};
    tbl[16] = '{1'b0, NONE,      1'b0, 32'h40, 32'h0,          1'b1, 32'h0,        4'h0};
    tbl[17] = '{1'b1, HALFWORD,  1'b0, 32'h22, 32'h0000_8001,  1'b0, 32'h0,        4'h0};
    tbl[18] = '{1'b0, HALFWORD,  1'b0, 32'h22, 32'h0,          1'b1, 32'hFFFF_8001, 4'hF};

    idle();
    req_mode = NONE; req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; if_addr = 32'h0;
    rst = 1'b1;
    step();
    chk("reset req_ready", req_ready, 1'b0);
    chk("reset if_ready", if_ready, 1'b0);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset if_rsp_valid", if_rsp_valid, 1'b0);
    chk("reset rsp_fault", rsp_fault, 1'b0);
    chk("reset rsp_data", rsp_data, 32'h0);
    chk("reset rsp_byte_mask", rsp_byte_mask, 4'h0);
    chk("reset if_rsp_data", if_rsp_data, 32'h0);
    rst = 1'b0;
    wait_clear("clear cycles");

    for (int i = 0; i < 19; i++) begin
      xfer(1'b1, tbl[i].w, tbl[i].md, tbl[i].uns, tbl[i].addr, tbl[i].wd, 1'b0, 32'h0);
      chk("tbl valid", rsp_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl data", rsp_data, tbl[i].ed);
        chk("tbl mask", rsp_byte_mask, tbl[i].em);
      end
    end

    // Same-word store and fetch: fetch sees the pre-store word.
    xfer(1'b1, 1'b1, WORD, 1'b0, 32'h40, 32'h1234_5678, 1'b1, 32'h43);
    chk("fetch read-first", if_rsp_data, 32'hCCDD_00AA);
    xfer(1'b1, 1'b0, WORD, 1'b0, 32'h40 | BYTES, 32'h0, 1'b1, 32'h41);
    chk("fetch after store", if_rsp_data, 32'h1234_5678);
    chk("wrapped load", rsp_data, 32'h1234_5678);
    idle();
    step();
    chk("idle rsp_valid", rsp_valid, 1'b0);

    for (int i = 0; i < 600; i++) begin
      ra = $urandom; ra[AW-1:7] = '0;
      fa2 = $urandom; fa2[AW-1:7] = '0;
      xfer(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           readWriteModes'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
           ra, $urandom, 1'($urandom_range(0, 1)), fa2);
    end
    idle();
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid-clear req_ready", req_ready, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_clear("reclear cycles");
    xfer(1'b1, 1'b0, WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
    chk("reclear word", rsp_data, CV);

    xfer(1'b1, 1'b1, WORD, 1'b0, 32'h41, 32'h5566_7788, 1'b0, 32'h0);
    xfer(1'b1, 1'b0, WORD, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    xfer(1'b1, 1'b0, HALFWORD, 1'b1, 32'h43, 32'h0, 1'b1, 32'h40);
    xfer(1'b1, 1'b0, WORDRIGHT, 1'b0, 32'h43, 32'h0, 1'b0, 32'h0);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
